// File: rtl/usb_utmi_tx_arbiter_if.sv
// Handshake bundle between the two TX requesters, the UTMI TX port and the
// arbiter status outputs.
interface usb_utmi_tx_arbiter_if;
  logic       req0_valid;
  logic [7:0] req0_data;
  logic       req0_last;
  logic       req0_ready;
  logic       req1_valid;
  logic [7:0] req1_data;
  logic       req1_last;
  logic       req1_ready;
  logic       utmi_txready;
  logic       utmi_rxactive;
  logic [7:0] utmi_data_out;
  logic       utmi_txvalid;
  logic [1:0] grant;
  logic       busy;
  logic       err_underrun;
  logic       err_timeout;

  modport slave (
    input  req0_valid, req0_data, req0_last,
    input  req1_valid, req1_data, req1_last,
    input  utmi_txready, utmi_rxactive,
    output req0_ready, req1_ready,
    output utmi_data_out, utmi_txvalid,
    output grant, busy, err_underrun, err_timeout
  );

  modport master (
    output req0_valid, req0_data, req0_last,
    output req1_valid, req1_data, req1_last,
    output utmi_txready, utmi_rxactive,
    input  req0_ready, req1_ready,
    input  utmi_data_out, utmi_txvalid,
    input  grant, busy, err_underrun, err_timeout
  );
endinterface

// File: rtl/usb_utmi_tx_arbiter.sv
// Packet-granular round-robin arbiter for the SoC-side UTMI TX path with
// rx deferral, inter-packet gap and underrun/txready-stall recovery.
module usb_utmi_tx_arbiter #(
  parameter int unsigned IPG_CYCLES      = 8,
  parameter int unsigned TXREADY_TIMEOUT = 1024
) (
  input logic                   ext_clk_i,
  input logic                   ext_rst_i,
  usb_utmi_tx_arbiter_if.slave  arb_if
);

  localparam logic [7:0]  GapLoad  = 8'(IPG_CYCLES - 1);
  localparam logic [15:0] ToLimit  = 16'(TXREADY_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, SEND, DRAIN, GAP} state_e;

  state_e      state_q, state_d;
  logic [1:0]  grant_q, grant_d;
  logic        ptr_q, ptr_d;
  logic        started_q, started_d;
  logic [7:0]  gap_q, gap_d;
  logic [15:0] to_q, to_d;

  logic       selValid;
  logic       selLast;
  logic [7:0] selData;
  logic       inSend;
  logic       accept;
  logic       stall;
  logic       discard;
  logic       favValid;
  logic       othValid;

  // grant_q is one-hot; req1 is selected only when bit 1 is set
  always_comb begin
    selValid = grant_q[1] ? arb_if.req1_valid : arb_if.req0_valid;
    selLast  = grant_q[1] ? arb_if.req1_last  : arb_if.req0_last;
    selData  = grant_q[1] ? arb_if.req1_data  : arb_if.req0_data;
    favValid = ptr_q ? arb_if.req1_valid : arb_if.req0_valid;
    othValid = ptr_q ? arb_if.req0_valid : arb_if.req1_valid;
  end

  assign inSend  = (state_q == SEND);
  assign accept  = inSend && selValid && arb_if.utmi_txready;
  assign stall   = inSend && selValid && !arb_if.utmi_txready;
  assign discard = (state_q == DRAIN) && selValid;

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    ptr_d     = ptr_q;
    started_d = started_q;
    gap_d     = gap_q;
    to_d      = to_q;
    unique case (state_q)
      IDLE: begin
        if (!arb_if.utmi_rxactive && (arb_if.req0_valid || arb_if.req1_valid)) begin
          state_d   = SEND;
          started_d = 1'b0;
          to_d      = '0;
          if (favValid) grant_d = ptr_q ? 2'b10 : 2'b01;
          else if (othValid) grant_d = ptr_q ? 2'b01 : 2'b10;
        end
      end
      SEND: begin
        if (accept) begin
          to_d      = '0;
          started_d = 1'b1;
          if (selLast) begin
            state_d = GAP;
            gap_d   = GapLoad;
            ptr_d   = grant_q[0];
            grant_d = 2'b00;
          end
        end else if (!selValid) begin
          if (started_q) state_d = DRAIN;
        end else if (to_q == ToLimit) begin
          state_d = DRAIN;
        end else begin
          to_d = to_q + 16'd1;
        end
      end
      DRAIN: begin
        if (discard && selLast) begin
          state_d = GAP;
          gap_d   = GapLoad;
          ptr_d   = grant_q[0];
          grant_d = 2'b00;
        end
      end
      GAP: begin
        if (gap_q == 8'd0) state_d = IDLE;
        else gap_d = gap_q - 8'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ext_clk_i) begin
    if (ext_rst_i) begin
      state_q   <= IDLE;
      grant_q   <= 2'b00;
      ptr_q     <= 1'b0;
      started_q <= 1'b0;
      gap_q     <= '0;
      to_q      <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      ptr_q     <= ptr_d;
      started_q <= started_d;
      gap_q     <= gap_d;
      to_q      <= to_d;
    end
  end

  // Ready is shared by the SEND handshake and the DRAIN discard path
  always_comb begin
    arb_if.utmi_txvalid  = inSend && selValid;
    arb_if.utmi_data_out = inSend ? selData : 8'h00;
    arb_if.req0_ready    = (accept || discard) && grant_q[0];
    arb_if.req1_ready    = (accept || discard) && grant_q[1];
    arb_if.grant         = grant_q;
    arb_if.busy          = (state_q != IDLE);
    arb_if.err_underrun  = inSend && !selValid && started_q;
    arb_if.err_timeout   = stall && (to_q == ToLimit);
  end

endmodule

// File: tb/tb_usb_utmi_tx_arbiter.sv
// Randomized and directed bench for usb_utmi_tx_arbiter with a packet-level
// reference model (per-requester byte queues, fairness pointer, gap counting).
module tb_usb_utmi_tx_arbiter;
  localparam int IPG  = 8;
  localparam int TOUT = 16;

  logic clk = 1'b0;
  logic ext_rst;
  usb_utmi_tx_arbiter_if arb();

  usb_utmi_tx_arbiter #(.IPG_CYCLES(IPG), .TXREADY_TIMEOUT(TOUT)) dut (
    .ext_clk_i (clk),
    .ext_rst_i (ext_rst),
    .arb_if    (arb)
  );

  always #5 clk = ~clk;

  logic [8:0] q0[$], q1[$], exp0[$], exp1[$];
  bit   en0, en1;
  logic txready, rxactive, rstReq;
  logic oTxv, oTxr, oRdy0, oRdy1, oBusy, oErrU, oErrT, oV0, oV1;
  logic [7:0] oData;
  logic [1:0] oGrant;
  int checks = 0, errors = 0;

  // Drive inputs from requester queues, sample on the falling edge, retire accepted bytes
  task automatic cycle();
    arb.req0_valid    = en0 && (q0.size() > 0);
    arb.req0_data     = (q0.size() > 0) ? q0[0][7:0] : 8'h00;
    arb.req0_last     = (q0.size() > 0) ? q0[0][8] : 1'b0;
    arb.req1_valid    = en1 && (q1.size() > 0);
    arb.req1_data     = (q1.size() > 0) ? q1[0][7:0] : 8'h00;
    arb.req1_last     = (q1.size() > 0) ? q1[0][8] : 1'b0;
    arb.utmi_txready  = txready;
    arb.utmi_rxactive = rxactive;
    ext_rst           = rstReq;
    @(negedge clk);
    oTxv = arb.utmi_txvalid; oTxr = arb.utmi_txready; oData = arb.utmi_data_out;
    oRdy0 = arb.req0_ready; oRdy1 = arb.req1_ready; oGrant = arb.grant;
    oBusy = arb.busy; oErrU = arb.err_underrun; oErrT = arb.err_timeout;
    oV0 = arb.req0_valid; oV1 = arb.req1_valid;
    if (arb.req0_valid && arb.req0_ready) void'(q0.pop_front());
    if (arb.req1_valid && arb.req1_ready) void'(q1.pop_front());
    @(posedge clk); #1;
  endtask

  task automatic doReset();
    rstReq = 1'b1; q0.delete(); q1.delete(); exp0.delete(); exp1.delete();
    en0 = 1; en1 = 1; txready = 1'b1; rxactive = 1'b0;
    cycle(); cycle();
    rstReq = 1'b0;
  endtask

  task automatic test_reset();
    doReset();
    rstReq = 1'b1; q0.push_back({1'b1, 8'h99}); txready = 1'b1;
    cycle(); cycle();
    checks++; if (oGrant !== 2'b00) begin errors++; $display("[TB] FAIL reset grant: got %b want 00", oGrant); end
    checks++; if (oTxv !== 1'b0) begin errors++; $display("[TB] FAIL reset txvalid: got %b want 0", oTxv); end
    checks++; if (oData !== 8'h00) begin errors++; $display("[TB] FAIL reset data: got %h want 00", oData); end
    checks++; if ({oRdy0, oRdy1} !== 2'b00) begin errors++; $display("[TB] FAIL reset ready: got %b want 00", {oRdy0, oRdy1}); end
    checks++; if (oBusy !== 1'b0) begin errors++; $display("[TB] FAIL reset busy: got %b want 0", oBusy); end
    checks++; if ({oErrU, oErrT} !== 2'b00) begin errors++; $display("[TB] FAIL reset err: got %b want 00", {oErrU, oErrT}); end
    rstReq = 1'b0;
  endtask

  task automatic test_single_packet();
    logic expTxv, expBusy;
    logic [7:0] expData;
    doReset();
    q0.push_back({1'b0, 8'hA1}); q0.push_back({1'b0, 8'hA2}); q0.push_back({1'b1, 8'hA3});
    for (int i = 0; i < 14; i++) begin
      cycle();
      expTxv  = (i >= 1 && i <= 3);
      expData = expTxv ? 8'hA0 + 8'(i) : 8'h00;
      expBusy = (i >= 1 && i <= 3 + IPG);
      checks++; if (oTxv !== expTxv) begin errors++; $display("[TB] FAIL single txvalid c%0d: got %b want %b", i, oTxv, expTxv); end
      checks++; if (oData !== expData) begin errors++; $display("[TB] FAIL single data c%0d: got %h want %h", i, oData, expData); end
      checks++; if (oBusy !== expBusy) begin errors++; $display("[TB] FAIL single busy c%0d: got %b want %b", i, oBusy, expBusy); end
      checks++; if (oGrant !== (expTxv ? 2'b01 : 2'b00)) begin errors++; $display("[TB] FAIL single grant c%0d: got %b", i, oGrant); end
    end
  endtask

  task automatic test_contention();
    int n = 0;
    int p, b;
    logic [1:0] expOwner;
    logic [7:0] expData;
    doReset();
    for (int k = 0; k < 4; k++) begin
      q0.push_back({1'b0, 8'h10 + 8'(2*k)}); q0.push_back({1'b1, 8'h11 + 8'(2*k)});
      q1.push_back({1'b0, 8'h20 + 8'(2*k)}); q1.push_back({1'b1, 8'h21 + 8'(2*k)});
    end
    for (int c = 0; c < 300 && (q0.size() > 0 || q1.size() > 0); c++) begin
      cycle();
      if (oTxv && oTxr) begin
        p = n / 2; b = n % 2;
        expOwner = (p % 2 == 0) ? 2'b01 : 2'b10;
        expData  = ((p % 2 == 0) ? 8'h10 : 8'h20) + 8'(2*(p/2) + b);
        checks++; if (oGrant !== expOwner) begin errors++; $display("[TB] FAIL contention grant byte %0d: got %b want %b", n, oGrant, expOwner); end
        checks++; if (oData !== expData) begin errors++; $display("[TB] FAIL contention data byte %0d: got %h want %h", n, oData, expData); end
        n++;
      end
    end
    checks++; if (n != 16) begin errors++; $display("[TB] FAIL contention count: got %0d want 16", n); end
  endtask

  task automatic test_backpressure();
    bit pat[10] = '{1, 1, 0, 0, 1, 1, 1, 1, 1, 1};
    int acc = 0;
    logic expTxv;
    doReset();
    for (int k = 0; k < 4; k++) q0.push_back({k == 3, 8'hB0 + 8'(k)});
    for (int i = 0; i < 10; i++) begin
      txready = pat[i];
      cycle();
      expTxv = (i >= 1 && acc < 4);
      checks++; if (oTxv !== expTxv) begin errors++; $display("[TB] FAIL backpressure txvalid c%0d: got %b want %b", i, oTxv, expTxv); end
      if (expTxv) begin
        checks++; if (oData !== 8'hB0 + 8'(acc)) begin errors++; $display("[TB] FAIL backpressure data c%0d: got %h want %h", i, oData, 8'hB0 + 8'(acc)); end
        checks++; if (oRdy0 !== txready) begin errors++; $display("[TB] FAIL backpressure ready c%0d: got %b want %b", i, oRdy0, txready); end
        if (txready) acc++;
      end
      checks++; if ({oErrU, oErrT} !== 2'b00) begin errors++; $display("[TB] FAIL backpressure err c%0d: got %b want 00", i, {oErrU, oErrT}); end
    end
    checks++; if (acc != 4) begin errors++; $display("[TB] FAIL backpressure accepted: got %0d want 4", acc); end
  endtask

  task automatic test_underrun();
    logic expTxv, expErrU, expRdy1;
    logic [1:0] expGrant;
    doReset();
    for (int k = 1; k <= 5; k++) q1.push_back({k == 5, 8'hC0 + 8'(k)});
    for (int i = 0; i < 19; i++) begin
      en1 = !(i == 3 || i == 4);
      if (i == 8) begin q0.push_back({1'b1, 8'hD1}); q1.push_back({1'b1, 8'hE1}); end
      cycle();
      expTxv   = (i == 1 || i == 2 || i == 17);
      expErrU  = (i == 3);
      expRdy1  = (i == 1 || i == 2 || (i >= 5 && i <= 7));
      expGrant = (i >= 1 && i <= 7) ? 2'b10 : (i == 17) ? 2'b01 : 2'b00;
      checks++; if (oTxv !== expTxv) begin errors++; $display("[TB] FAIL underrun txvalid c%0d: got %b want %b", i, oTxv, expTxv); end
      checks++; if (oErrU !== expErrU) begin errors++; $display("[TB] FAIL underrun pulse c%0d: got %b want %b", i, oErrU, expErrU); end
      checks++; if (oRdy1 !== expRdy1) begin errors++; $display("[TB] FAIL underrun ready1 c%0d: got %b want %b", i, oRdy1, expRdy1); end
      checks++; if (oGrant !== expGrant) begin errors++; $display("[TB] FAIL underrun grant c%0d: got %b want %b", i, oGrant, expGrant); end
      if (i == 17) begin
        checks++; if (oData !== 8'hD1) begin errors++; $display("[TB] FAIL underrun next data: got %h want D1", oData); end
      end
    end
  endtask

  task automatic test_timeout();
    int stallEnd = 1 + TOUT;
    int drainEnd = stallEnd + 3;
    int idleAt   = drainEnd + IPG + 1;
    logic expTxv, expErrT, expRdy0, expBusy;
    doReset();
    for (int k = 0; k < 4; k++) q0.push_back({k == 3, 8'h50 + 8'(k)});
    for (int i = 0; i <= idleAt + 1; i++) begin
      txready = (i <= 1);
      cycle();
      expTxv  = (i >= 1 && i <= stallEnd);
      expErrT = (i == stallEnd);
      expRdy0 = (i == 1) || (i > stallEnd && i <= drainEnd);
      expBusy = (i >= 1 && i < idleAt);
      checks++; if (oTxv !== expTxv) begin errors++; $display("[TB] FAIL timeout txvalid c%0d: got %b want %b", i, oTxv, expTxv); end
      checks++; if (oErrT !== expErrT) begin errors++; $display("[TB] FAIL timeout pulse c%0d: got %b want %b", i, oErrT, expErrT); end
      checks++; if (oRdy0 !== expRdy0) begin errors++; $display("[TB] FAIL timeout ready0 c%0d: got %b want %b", i, oRdy0, expRdy0); end
      checks++; if (oBusy !== expBusy) begin errors++; $display("[TB] FAIL timeout busy c%0d: got %b want %b", i, oBusy, expBusy); end
    end
  endtask

  task automatic test_rx_and_reset();
    doReset();
    q0.push_back({1'b1, 8'h77});
    for (int i = 0; i < 8; i++) begin
      rxactive = (i < 5);
      cycle();
      checks++; if (oGrant !== ((i == 6) ? 2'b01 : 2'b00)) begin errors++; $display("[TB] FAIL rxactive grant c%0d: got %b", i, oGrant); end
      checks++; if (oTxv !== (i == 6)) begin errors++; $display("[TB] FAIL rxactive txvalid c%0d: got %b", i, oTxv); end
    end
    for (int i = 0; i < IPG + 2; i++) cycle();
    q1.push_back({1'b0, 8'h31}); q1.push_back({1'b0, 8'h32}); q1.push_back({1'b1, 8'h33});
    cycle(); cycle();
    checks++; if (oGrant !== 2'b10 || oTxv !== 1'b1) begin errors++; $display("[TB] FAIL midreset pre grant: got %b txv %b want 10 1", oGrant, oTxv); end
    rstReq = 1'b1;
    cycle();
    rstReq = 1'b0;
    q1.delete(); q0.push_back({1'b1, 8'h41}); q1.push_back({1'b1, 8'h42});
    cycle();
    checks++; if ({oGrant, oTxv, oBusy, oRdy0, oRdy1} !== 6'b0) begin errors++; $display("[TB] FAIL midreset state: got g%b v%b b%b r%b%b want zeros", oGrant, oTxv, oBusy, oRdy0, oRdy1); end
    checks++; if (oData !== 8'h00) begin errors++; $display("[TB] FAIL midreset data: got %h want 00", oData); end
    cycle();
    checks++; if (oGrant !== 2'b01 || oData !== 8'h41) begin errors++; $display("[TB] FAIL midreset favour: got %b %h want 01 41", oGrant, oData); end
  endtask

  task automatic genPacket(int who);
    int len = $urandom_range(1, 5);
    logic [8:0] e;
    for (int b = 0; b < len; b++) begin
      e = {b == len - 1, 8'($urandom)};
      if (who == 0) begin q0.push_back(e); exp0.push_back(e); end
      else begin q1.push_back(e); exp1.push_back(e); end
    end
  endtask

  task automatic test_random_traffic();
    int fav = 0, sinceEnd = 0, stallRun = 0, pkts = 0;
    bit haveEnd = 0;
    logic pBusy = 0, pRx = 0, pV0 = 0, pV1 = 0, pTxv = 0;
    logic [1:0] pGrant = 0, expG;
    logic [8:0] e;
    logic favV, othV;
    doReset();
    for (int c = 0; c < 1100; c++) begin
      if (c < 800 && q0.size() == 0 && $urandom_range(0, 7) == 0) genPacket(0);
      if (c < 800 && q1.size() == 0 && $urandom_range(0, 7) == 0) genPacket(1);
      txready  = (stallRun >= 6) ? 1'b1 : ($urandom_range(0, 3) != 0);
      stallRun = txready ? 0 : stallRun + 1;
      rxactive = ($urandom_range(0, 5) == 0);
      cycle();
      if (!pBusy && pGrant == 2'b00) begin
        favV = (fav == 0) ? pV0 : pV1;
        othV = (fav == 0) ? pV1 : pV0;
        if (pRx || !(favV || othV)) expG = 2'b00;
        else if (favV) expG = (fav == 0) ? 2'b01 : 2'b10;
        else expG = (fav == 0) ? 2'b10 : 2'b01;
        checks++; if (oGrant !== expG) begin errors++; $display("[TB] FAIL random arbitration c%0d: got %b want %b", c, oGrant, expG); end
      end
      checks++; if ({oErrU, oErrT} !== 2'b00) begin errors++; $display("[TB] FAIL random err c%0d: got %b want 00", c, {oErrU, oErrT}); end
      if (oTxv && !pTxv && haveEnd) begin
        checks++; if (sinceEnd < IPG + 1) begin errors++; $display("[TB] FAIL random gap c%0d: got %0d want >= %0d", c, sinceEnd, IPG + 1); end
        haveEnd = 0;
      end
      if (oTxv && oTxr) begin
        if (oGrant == 2'b01 && exp0.size() > 0) e = exp0.pop_front();
        else if (oGrant == 2'b10 && exp1.size() > 0) e = exp1.pop_front();
        else e = 9'h1FF;
        checks++; if (e === 9'h1FF || oData !== e[7:0]) begin errors++; $display("[TB] FAIL random byte c%0d: got %h grant %b want %h", c, oData, oGrant, e[7:0]); end
        checks++; if ({oRdy1, oRdy0} !== oGrant) begin errors++; $display("[TB] FAIL random ready c%0d: got %b%b want %b", c, oRdy1, oRdy0, oGrant); end
        if (e[8]) begin fav = (oGrant == 2'b01) ? 1 : 0; haveEnd = 1; sinceEnd = 0; pkts++; end
      end else if (!oTxv && haveEnd) begin
        sinceEnd++;
      end
      pBusy = oBusy; pRx = rxactive; pV0 = oV0; pV1 = oV1; pGrant = oGrant; pTxv = oTxv;
    end
    checks++; if (exp0.size() != 0 || exp1.size() != 0) begin errors++; $display("[TB] FAIL random leftover: got %0d/%0d want 0/0", exp0.size(), exp1.size()); end
    checks++; if (pkts == 0) begin errors++; $display("[TB] FAIL random packets: got 0 want >0"); end
  endtask

  initial begin
    rstReq = 1'b1; en0 = 1; en1 = 1; txready = 1'b1; rxactive = 1'b0;
    test_reset();
    test_single_packet();
    test_contention();
    test_backpressure();
    test_underrun();
    test_timeout();
    test_rx_and_reset();
    test_random_traffic();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "[TB] watchdog expired");
  end
endmodule

// File: doc/usb_utmi_tx_arbiter.md
Name: usb_utmi_tx_arbiter

Overview:
- Packet-granular arbiter and sequencer for the SoC-side UTMI TX path. It runs in the SoC clock domain, upstream of the UTMI→ULPI CDC stage.
- Two byte-stream requesters share one UTMI TX port: requester 0 is the USB host engine, requester 1 is the debug/test packet injector.
- It enforces round-robin fairness per packet, defers TX while the bus is receiving, and inserts a minimum inter-packet gap.
- It recovers from requester underrun and PHY txready stall without wedging the bus.

Parameters:
- IPG_CYCLES, 8: idle ext_clk cycles between end of one packet and next grant; legal 1..255.
- TXREADY_TIMEOUT, 1024: consecutive SEND cycles with txvalid=1 and txready=0 before abort; legal 2..65535.

Ports:
- ext_clk  in  1  SoC clock; all logic on rising edge.
- ext_rst  in  1  synchronous, active-high reset.
- req0_valid  in  1  requester 0 byte valid.
- req0_data  in  8  requester 0 byte.
- req0_last  in  1  marks final byte of packet (qualified by valid).
- req0_ready  out  1  byte accepted this cycle.
- req1_valid, req1_data[7:0], req1_last in / req1_ready out: same as requester 0.
- utmi_txready  in  1  from CDC'd UTMI bridge.
- utmi_rxactive  in  1  from CDC'd UTMI bridge; bus busy receiving.
- utmi_data_out  out  8  TX byte to UTMI.
- utmi_txvalid  out  1  TX valid to UTMI.
- grant  out  2  one-hot current owner; 2'b00 when none.
- busy  out  1  state != IDLE.
- err_underrun  out  1  one-cycle pulse.
- err_timeout  out  1  one-cycle pulse.

Behaviour:
- Reset values:
  - state=IDLE, grant=00, utmi_txvalid=0, utmi_data_out=00, both ready=0, busy=0, both err=0.
  - Round-robin pointer favours req0; gap and timeout counters = 0.
- States: IDLE, SEND, DRAIN, GAP.
- IDLE:
  - If utmi_rxactive=0 and any reqN_valid=1, register grant to the winner and go to SEND next cycle.
  - Winner is the pointer-favoured requester if it is valid, otherwise the other one.
  - If utmi_rxactive=1, stay in IDLE regardless of requests.
- SEND:
  - Combinational outputs: utmi_data_out=granted data, utmi_txvalid=granted valid, granted ready=utmi_txready & granted valid, other ready=0.
  - Arbitration latency: 1 cycle from valid in IDLE to txvalid.
  - Accepted byte: txvalid & txready same cycle.
  - Accepted byte with last=1: go to GAP, load gap counter with IPG_CYCLES-1, flip pointer to favour the non-granted requester, grant→00.
  - Underrun: granted valid=0 in any SEND cycle after the first byte has been accepted. Pulse err_underrun, go to DRAIN.
  - Granted valid=0 before the first accepted byte is a wait, not an error.
  - Timeout counter: increments each SEND cycle with txvalid=1 & txready=0, clears on any accepted byte.
  - When the counter reaches TXREADY_TIMEOUT-1 without acceptance: pulse err_timeout, go to DRAIN.
  - utmi_rxactive rising during SEND is ignored; the packet continues.
- DRAIN:
  - utmi_txvalid=0; granted ready=granted valid (discard bytes).
  - Exit to GAP on a discarded byte with last=1, with the same pointer/gap handling as a normal end.
- GAP:
  - Outputs idle, ready=0, grant=00.
  - Counter decrements each cycle; go to IDLE on the cycle the counter is 0.
  - Total idle cycles between last accept and next txvalid ≥ IPG_CYCLES+1 (gap + arbitration).
- Counter widths: gap counter 8 bits; timeout counter 16 bits. Neither wraps (saturation is unreachable by construction).
- ext_rst mid-packet: immediate return to reset values at the next edge. utmi_txvalid drops with no last byte. The requester is responsible for its own flush.
- Each requester must hold data/last stable while valid=1 & ready=0.

Test Plan:
- Single packet:
  - Stimulus: req0 sends 3 bytes A1,A2,A3 (last on A3), txready always 1, IPG_CYCLES=8.
  - Required: txvalid high exactly 3 cycles starting 1 cycle after req0_valid; data A1..A3; busy low 9 cycles after A3 accepted.
- Contention:
  - Stimulus: both requesters continuously offer 2-byte packets.
  - Required: grants alternate 01,10,01,10 after reset; no byte interleaving between packets.
- Backpressure:
  - Stimulus: txready toggles 1,0,0,1 during a 4-byte packet.
  - Required: each byte presented until accepted; ready mirrors txready; no err pulses.
- Underrun:
  - Stimulus: req1 drops valid after byte 2 of 5, then resumes and delivers bytes 3–5 with last.
  - Required: err_underrun pulses once; txvalid=0 from the drop onward; bytes 3–5 acked with txvalid=0; next grant to req0 after the gap.
- Timeout:
  - Stimulus: TXREADY_TIMEOUT=16, txready held 0 after first byte.
  - Required: err_timeout pulses on the 16th stalled cycle; DRAIN consumes the rest to last; return to IDLE after the gap.
- rxactive and reset:
  - Stimulus: rxactive=1 while req0 valid.
  - Required: no grant until rxactive falls, then txvalid 1 cycle later.
  - Stimulus: assert ext_rst mid-packet.
  - Required: all outputs at reset values after the next edge; req0 favoured again.
